// File: rtl/prime_pkg.sv
// Shared definitions for the prime detection / collection pipeline.
//
// Contents:
//   DEF_WIDTH, DEF_CNT_W : default number width and statistic counter width
//   num_t, cnt_t         : number and counter types at the default widths
//                          (prime_detect uses num_t as well)
//   sat_inc              : width-agnostic saturating increment
package prime_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 16;

  typedef logic [DEF_WIDTH-1:0] num_t;
  typedef logic [DEF_CNT_W-1:0] cnt_t;

  // Works on a 64-bit carrier so modules with non-default counter widths can
  // share it. The caller truncates the result back to its own width.
  // width must be below 64.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_v;
    max_v = (64'd1 << width) - 64'd1;
    return (value >= max_v) ? max_v : value + 64'd1;
  endfunction

endpackage

// File: rtl/prime_fifo.sv
// First-word-fall-through FIFO that holds the accepted primes.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   clear      : synchronous flush; overrides push and pop in the same cycle
//   push/wdata : write request and data (ignored while full)
//   pop        : read request (ignored while empty)
//   rdata      : entry at the read pointer, 0 while empty
//   level      : occupancy 0..DEPTH
//   full/empty : occupancy flags derived from level
module prime_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two; level is kept
  // separately so full and empty are never ambiguous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: rdata is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/prime_collector.sv
// Streaming stage behind prime_detect. Buffers the numbers flagged as prime
// in an order-preserving FIFO for a valid/ready consumer and keeps running
// statistics over every accepted beat.
//
// Ports:
//   clk, rst_n             : rising-edge clock, asynchronous active-low reset
//   clear                  : synchronous flush of FIFO and statistics
//   in_valid/in_ready      : upstream handshake
//   in_n, in_is_prime      : tested number and its verdict
//   out_valid/out_ready    : downstream handshake, out_data = oldest prime
//   level                  : FIFO occupancy 0..DEPTH
//   seen_cnt, prime_cnt    : saturating counts of accepted beats and primes
//   max_prime, max_valid   : largest accepted prime and its valid flag
module prime_collector
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_n,
  input  logic                   in_is_prime,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       seen_cnt,
  output logic [CNT_W-1:0]       prime_cnt,
  output logic [WIDTH-1:0]       max_prime,
  output logic                   max_valid
);

  logic run_q;
  logic accept;
  logic push;
  logic pop;
  logic full;
  logic empty;

  // Holds in_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Full stalls every beat, not just primes, so the statistics stay in
  // arrival order with the buffered data.
  assign in_ready  = run_q && !full && !clear;
  assign accept    = in_valid && in_ready;
  assign push      = accept && in_is_prime;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready && !clear;

  prime_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (in_n),
    .rdata (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_cnt  <= '0;
      prime_cnt <= '0;
    end else if (clear) begin
      seen_cnt  <= '0;
      prime_cnt <= '0;
    end else if (accept) begin
      seen_cnt <= CNT_W'(sat_inc(64'(seen_cnt), CNT_W));
      if (in_is_prime) prime_cnt <= CNT_W'(sat_inc(64'(prime_cnt), CNT_W));
    end
  end

  // Strictly greater: an equal prime leaves the stored maximum untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_prime <= '0;
      max_valid <= 1'b0;
    end else if (clear) begin
      max_prime <= '0;
      max_valid <= 1'b0;
    end else if (push && (!max_valid || (in_n > max_prime))) begin
      max_prime <= in_n;
      max_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prime_collector.sv
module tb_prime_collector;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   rst_n;
  logic                   clear;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_n;
  logic                   in_is_prime;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       seen_cnt;
  logic [CNT_W-1:0]       prime_cnt;
  logic [WIDTH-1:0]       max_prime;
  logic                   max_valid;

  prime_collector #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_n        (in_n),
    .in_is_prime (in_is_prime),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .seen_cnt    (seen_cnt),
    .prime_cnt   (prime_cnt),
    .max_prime   (max_prime),
    .max_valid   (max_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the primes still owed to the consumer, in order, plus
  // unbounded totals that are clamped only when compared.
  logic [WIDTH-1:0] sb[$];
  int               seen_total;
  int               prime_total;
  logic [WIDTH-1:0] max_seen;
  bit               any_prime;
  bit               exp_ready;
  bit               exp_valid;

  function automatic void modelReset();
    sb.delete();
    seen_total  = 0;
    prime_total = 0;
    max_seen    = '0;
    any_prime   = 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, " out_valid"}, 64'(out_valid), 0);
    checkOutput({tag, " in_ready"},  64'(in_ready),  0);
    checkOutput({tag, " level"},     64'(level),     0);
    checkOutput({tag, " seen_cnt"},  64'(seen_cnt),  0);
    checkOutput({tag, " prime_cnt"}, 64'(prime_cnt), 0);
    checkOutput({tag, " max_prime"}, 64'(max_prime), 0);
    checkOutput({tag, " max_valid"}, 64'(max_valid), 0);
    checkOutput({tag, " out_data"},  64'(out_data),  0);
  endtask

  // Per-cycle state check, 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        exp_ready = 1'b0;
        exp_valid = 1'b0;
        checkZero("in_reset");
      end else begin
        exp_ready = (sb.size() < DEPTH) && !clear;
        exp_valid = (sb.size() != 0);
        checkOutput("level",     64'(level),     64'(sb.size()));
        checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
        checkOutput("in_ready",  64'(in_ready),  64'(exp_ready));
        checkOutput("seen_cnt",  64'(seen_cnt),
                    64'((seen_total > CNT_MAX) ? CNT_MAX : seen_total));
        checkOutput("prime_cnt", 64'(prime_cnt),
                    64'((prime_total > CNT_MAX) ? CNT_MAX : prime_total));
        checkOutput("max_prime", 64'(max_prime), 64'(any_prime ? max_seen : '0));
        checkOutput("max_valid", 64'(max_valid), 64'(any_prime));
      end
    end
  end

  // Stimulus observer: each beat the model says will be accepted pushes its
  // expectation into the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (clear) begin
        modelReset();
      end else if (in_valid && exp_ready) begin
        seen_total++;
        if (in_is_prime) begin
          sb.push_back(in_n);
          prime_total++;
          if (!any_prime || in_n > max_seen) max_seen = in_n;
          any_prime = 1'b1;
        end
      end
    end
  end

  // Output monitor: compares the presented head and pops on a handshake.
  always @(negedge clk) begin
    if (rst_n && !clear) begin
      if (exp_valid) begin
        checkOutput("out_data", 64'(out_data), 64'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end else begin
        checkOutput("out_data_empty", 64'(out_data), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the model says it is taken.
  task automatic applyStimulus(input logic [WIDTH-1:0] n, input logic p);
    bit done;
    done        = 1'b0;
    in_valid    = 1'b1;
    in_n        = n;
    in_is_prime = p;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (exp_ready) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL accept_timeout: beat %0d got no acceptance, required acceptance", n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    tick();
    checkOutput("drain_level", 64'(level), 0);
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("async_reset");
    modelReset();
    exp_ready = 1'b0;
    exp_valid = 1'b0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [WIDTH-1:0] t1_n[6] = '{12, 19, 7, 15, 17, 1999};
    logic             t1_p[6] = '{0, 1, 1, 0, 1, 1};
    logic [WIDTH-1:0] pr[9]   = '{2, 3, 5, 7, 11, 13, 17, 19, 23};

    modelReset();
    exp_ready   = 1'b0;
    exp_valid   = 1'b0;
    rst_n       = 1'b1;
    clear       = 1'b0;
    in_valid    = 1'b0;
    in_n        = '0;
    in_is_prime = 1'b0;
    out_ready   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] mixed stream");
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(t1_n[i], t1_p[i]);
    drain();
    checkOutput("t1_seen",  64'(seen_cnt),  6);
    checkOutput("t1_prime", 64'(prime_cnt), 4);
    checkOutput("t1_max",   64'(max_prime), 1999);
    checkOutput("t1_maxv",  64'(max_valid), 1);

    $display("[TB] full stall");
    doClear();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(pr[i], 1'b1);
    in_valid = 1'b1; in_n = pr[8]; in_is_prime = 1'b1;
    repeat (3) tick();
    checkOutput("t2_in_ready_full", 64'(in_ready), 0);
    checkOutput("t2_level_full",    64'(level),    8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("t2_in_ready_after_pop", 64'(in_ready), 1);
    applyStimulus(pr[8], 1'b1);
    drain();

    $display("[TB] full with simultaneous push and pop");
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(pr[i] + 100, 1'b1);
    in_valid = 1'b1; in_n = 29; in_is_prime = 1'b1; out_ready = 1'b1;
    #1;
    checkOutput("t3_in_ready_full", 64'(in_ready), 0);
    applyStimulus(29, 1'b1);
    drain();

    $display("[TB] equal maximum");
    doClear();
    applyStimulus(31, 1'b1);
    applyStimulus(5, 1'b1);
    applyStimulus(31, 1'b1);
    checkOutput("t4_max",   64'(max_prime), 31);
    checkOutput("t4_prime", 64'(prime_cnt), 3);
    drain();

    $display("[TB] clear with pending beat");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(pr[i], 1'b1);
    in_valid = 1'b1; in_n = 41; in_is_prime = 1'b1; clear = 1'b1;
    #1;
    checkOutput("t5_in_ready_clear", 64'(in_ready), 0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("t5_level",  64'(level),     0);
    checkOutput("t5_valid",  64'(out_valid), 0);
    checkOutput("t5_seen",   64'(seen_cnt),  0);
    checkOutput("t5_maxv",   64'(max_valid), 0);
    tick();

    $display("[TB] counter saturation");
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(WIDTH'(2 * i + 4), 1'b0);
    checkOutput("t6_seen",  64'(seen_cnt),  15);
    checkOutput("t6_prime", 64'(prime_cnt), 0);
    checkOutput("t6_valid", 64'(out_valid), 0);

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(pr[i], 1'b1);
    doReset();

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_is_prime = 1'($urandom_range(0, 1));
      in_n        = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : $urandom;
      out_ready   = ($urandom_range(0, 2) != 0);
      clear       = ($urandom_range(0, 39) == 0);
      if (c == 200) doReset();
      else          tick();
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
